hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the five-stage core.
- Decides each cycle whether the PC, IF/ID, ID/EX and EX/MEM registers load, hold or take a bubble.
- Covers load-use hazards, EX-resolved branch redirects and multi-cycle data-memory waits; also generates EX-stage forwarding selects.
- Sits beside the decoder and drives the enable/flush inputs of the stage registers; the ID/EX register gains stall (hold) and flush (bubble) inputs driven from here.

Parameters:
- REG_AW, 5, register index width.
- MEM_TIMEOUT, 255, max cycles in MEM_WAIT before mem_err is raised (max 65535).
- CNT_W, 32, width of the stall/flush performance counters.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  REG_AW each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rd  in  REG_AW  destination register of the EX instruction.
- ex_reg_write  in  1  EX instruction writes rd.
- ex_is_load  in  1  EX instruction is a load.
- mem_rd  in  REG_AW  destination register of the MEM instruction.
- mem_reg_write  in  1  MEM instruction writes rd.
- ex_pc_sel  in  1  branch/jump taken, resolved in EX.
- dmem_req  in  1  MEM stage issues an access.
- dmem_ack  in  1  memory completes the access.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the register.
- if_id_flush, id_ex_flush  out  1 each  load a bubble.
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
- mem_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Single clock sys_clk; reset sys_rst is synchronous and active-high.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when dmem_req && !dmem_ack.
  - MEM_WAIT -> RUN in the cycle dmem_ack=1; control outputs in that cycle are as in RUN.
- Control outputs are combinational from the FSM state, registered flags and current inputs.
- Priority: mem-wait freeze > redirect > load-use.
- Freeze (state MEM_WAIT, or RUN with dmem_req && !dmem_ack):
  - all four stall outputs = 1, both flush outputs = 0.
  - A redirect or load-use condition present during the freeze is re-evaluated after the freeze; inputs are held by the frozen registers.
- Redirect (ex_pc_sel=1, no freeze):
  - if_id_flush = 1, id_ex_flush = 1, stalls = 0, for exactly one cycle.
  - Any load-use condition in that cycle is ignored (the ID instruction is squashed).
- Load-use, detected when all of:
  - ex_is_load && ex_reg_write && ex_rd != 0, and
  - (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd).
- Load-use response (no freeze, no redirect): pc_stall = 1, if_id_stall = 1, id_ex_flush = 1, ex_mem_stall = 0, for one cycle. The bubble clears ex_is_load next cycle, so the stall self-terminates.
- Forwarding (operand A; B identical using id_rs2 and fwd_b_sel), evaluated from registered copies of the ID sources, i.e. the operands now in EX:
  - EX/MEM match with rd != 0 -> fwd_a_sel = 1;
  - else MEM/WB match with rd != 0 -> 2;
  - else 0.
  - Younger stage wins when both match. Selects are don't-care during a freeze but must not glitch to 3.
- Timeout counter (16 bit, saturating):
  - clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - reaching MEM_TIMEOUT sets mem_err (sticky until reset) and forces MEM_WAIT -> RUN.
- stall_cnt: +1 each cycle pc_stall = 1.
- flush_cnt: +1 each redirect cycle.
- Both counters wrap modulo 2^CNT_W.
- Reset (sys_rst = 1 at a clock edge):
  - FSM -> RUN, counters = 0, mem_err = 0, forwarding registers = 0.
  - While sys_rst is high: all stall outputs = 0, if_id_flush = 1, id_ex_flush = 1 (pipeline fills with bubbles), fwd selects = 0.
  - Reset mid-MEM_WAIT abandons the wait; dmem_ack arriving after reset is ignored unless dmem_req is high.

Decomposition:
- Shared package: FSM state encoding (ST_RUN, ST_MEM_WAIT) and forwarding select constants (FWD_RF = 0, FWD_EXMEM = 1, FWD_MEMWB = 2).
- One natural sub-module, fwd_unit: combinational, per operand; instantiated twice.

Test Plan:
- Load-use stall: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cnt 0->1; next cycle (ex_is_load=0) all outputs 0.
- Load to x0: same stimulus with ex_rd=0 -> no stall.
- Redirect beats load-use: ex_pc_sel=1 with the load-use condition -> if_id_flush=1, id_ex_flush=1, pc_stall=0, flush_cnt=1.
- Memory wait:
  - dmem_req=1, ack low for 3 cycles -> all stalls=1 for 3 cycles; ack in cycle 4 -> RUN, stalls=0.
  - Ack held low with MEM_TIMEOUT=4 -> mem_err=1 after 4 wait cycles, FSM returns to RUN, mem_err stays 1 until reset.
- Forwarding priority: ID rs1=7 (registered into EX), ex_rd=7/ex_reg_write=1, mem_rd=7/mem_reg_write=1 -> fwd_a_sel=1; clear ex_reg_write -> 2; rd=0 -> 0.
- Reset mid-wait: sys_rst during MEM_WAIT -> next cycle state RUN, counters 0, flush outputs 1 while sys_rst is high.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding selects,
// and the width of the memory-wait timeout counter.
package hazard_ctrl_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam int unsigned TMO_W = 16;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Per-operand forwarding select for the EX stage; the younger producer wins.
module fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    output logic [1:0]        sel_c
);

    always_comb begin
        sel_c = FWD_RF;
        if (ex_reg_write && (ex_rd != '0) && (src == ex_rd)) begin
            sel_c = FWD_EXMEM;
        end else if (mem_reg_write && (mem_rd != '0) && (src == mem_rd)) begin
            sel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: freezes on data-memory waits, flushes on EX redirects,
// bubbles load-use hazards and produces EX forwarding selects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              ex_pc_sel,
    input  logic              dmem_req,
    input  logic              dmem_ack,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_stall,
    output logic              ex_mem_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    logic [0:0]        state, state_nxt;
    logic [TMO_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic              mem_err_nxt;
    logic              freeze, redirect, load_use, hazard_c;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q;
    logic [1:0]        fwd_a_c, fwd_b_c;

    assign hazard_c = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, timeout tracking and stage-register control, in priority order.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err;
        freeze       = 1'b0;
        redirect     = 1'b0;
        load_use     = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;

        case (state)
            ST_RUN: begin
                if (dmem_req && !dmem_ack) begin
                    freeze       = 1'b1;
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack) begin
                    state_nxt = ST_RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt != '1) begin
                        wait_cnt_nxt = wait_cnt + TMO_W'(1);
                    end
                    if (wait_cnt_nxt >= TMO_LIMIT) begin
                        mem_err_nxt = 1'b1;
                        state_nxt   = ST_RUN;
                    end
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        redirect = !freeze && ex_pc_sel;
        load_use = !freeze && !redirect && hazard_c;

        if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end

        // Reset fills the pipeline with bubbles.
        if (sys_rst) begin
            redirect     = 1'b0;
            load_use     = 1'b0;
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            id_ex_stall  = 1'b0;
            ex_mem_stall = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end
    end

    // Timeout, sticky error, performance counters and the EX copies of the ID sources.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err_nxt;
            if (pc_stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (!id_ex_stall) begin
                ex_rs1_q <= id_ex_flush ? '0 : id_rs1;
                ex_rs2_q <= id_ex_flush ? '0 : id_rs2;
            end
        end
    end

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src           (ex_rs1_q),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .sel_c         (fwd_a_c)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src           (ex_rs2_q),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .sel_c         (fwd_b_c)
    );

    assign fwd_a_sel = sys_rst ? FWD_RF : fwd_a_c;
    assign fwd_b_sel = sys_rst ? FWD_RF : fwd_b_c;

endmodule
